// File: rtl/sspwm_pulse_sine_gen_if.sv
// rtl/sspwm_pulse_sine_gen_if.sv - sample stream from the SSPWM sine generator to the comparator
interface sspwm_pulse_sine_gen_if #(
    parameter int OUT_W = 12
);
    logic [OUT_W-1:0] sine_out;
    logic             polarity;
    logic             out_valid;
    logic             period_start;

    modport master (output sine_out, polarity, out_valid, period_start);
    modport slave  (input  sine_out, polarity, out_valid, period_start);
endinterface

// File: rtl/sspwm_pulse_sine_gen.sv
// rtl/sspwm_pulse_sine_gen.sv - tick-stepped off-window + half-sine reference for the SSPWM comparator
module sspwm_pulse_sine_gen #(
    parameter int OUT_W     = 12,
    parameter int IDX_W     = 8,
    parameter int OFF_STEPS = 20,
    parameter int ON_STEPS  = 20,
    parameter int PERIOD    = 40,
    parameter int AMP_MAX   = 3711,
    parameter int BIPOLAR   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   oneshot,
    input  logic [8:0]             gain,
    sspwm_pulse_sine_gen_if.master smp,
    output logic                   busy
);
    localparam int  Q  = ON_STEPS / 2;
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    // Nearest integer, exact .5 falls back toward zero (values are never negative).
    function automatic int rom_val(input int k);
        real v;
        int  r;
        v = AMP_MAX * $sin(PI * k / ON_STEPS);
        r = $rtoi(v);
        if (v - r > 0.5)
            r = r + 1;
        return r;
    endfunction

    logic [OUT_W-1:0] rom [0:Q];

    for (genvar g = 0; g <= Q; g++) begin : g_rom
        localparam logic [OUT_W-1:0] VAL = OUT_W'(rom_val(g));
        assign rom[g] = VAL;
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             phase, oneshot_q, os_done;
    logic [8:0]       gain_q;
    logic             launch, last;
    logic [OUT_W-1:0] lobe;
    int               kk, kq;

    logic             s1_valid, s1_pol, s1_start;
    logic [OUT_W-1:0] s1_lobe;
    logic [OUT_W-1:0] scaled;

    assign last   = (idx == IDX_W'(PERIOD - 1));
    assign busy   = (state_q != IDLE);
    assign scaled = OUT_W'(((OUT_W+8)'(s1_lobe) * (OUT_W+8)'(gain_q)) >> 8);

    always_comb begin
        lobe = '0;
        kk   = int'(idx) - OFF_STEPS;
        kq   = (kk <= Q) ? kk : ON_STEPS - kk;
        if (kk >= 0 && kk < ON_STEPS) begin
            for (int g = 0; g <= Q; g++)
                if (kq == g)
                    lobe = rom[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A finished one-shot parks in IDLE until en is released (os_done).
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !os_done)
                    state_d = RUN;
            end
            RUN, STOPPING: begin
                launch = tick;
                if (launch && last && (oneshot_q || !en))
                    state_d = IDLE;
                else if (en)
                    state_d = RUN;
                else
                    state_d = STOPPING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            phase     <= 1'b0;
            oneshot_q <= 1'b0;
            os_done   <= 1'b0;
            gain_q    <= 9'd256;
        end else begin
            if (state_q == IDLE) begin
                idx <= '0;
                if (en && !os_done)
                    oneshot_q <= oneshot;
            end
            if (!en)
                os_done <= 1'b0;
            else if (launch && last && oneshot_q)
                os_done <= 1'b1;
            if (launch) begin
                idx <= last ? '0 : idx + IDX_W'(1);
                if (last && BIPOLAR != 0)
                    phase <= ~phase;
                if (idx == '0)
                    gain_q <= (gain > 9'd256) ? 9'd256 : gain;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_lobe          <= '0;
            s1_pol           <= 1'b0;
            s1_start         <= 1'b0;
            smp.sine_out     <= '0;
            smp.polarity     <= 1'b0;
            smp.out_valid    <= 1'b0;
            smp.period_start <= 1'b0;
        end else begin
            s1_valid <= launch;
            if (launch) begin
                s1_lobe  <= lobe;
                s1_pol   <= phase;
                s1_start <= (idx == '0);
            end
            smp.out_valid    <= s1_valid;
            smp.period_start <= s1_valid & s1_start;
            if (s1_valid) begin
                smp.sine_out <= scaled;
                smp.polarity <= s1_pol;
            end
        end
    end
endmodule

// File: tb/tb_sspwm_pulse_sine_gen.sv
// tb/tb_sspwm_pulse_sine_gen.sv - directed self-checking bench for sspwm_pulse_sine_gen
module tb_sspwm_pulse_sine_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       oneshot = 1'b0;
    logic [8:0] gain = 9'd256;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int base;

    sspwm_pulse_sine_gen_if #(.OUT_W(12)) smp ();

    sspwm_pulse_sine_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tick    (tick),
        .oneshot (oneshot),
        .gain    (gain),
        .smp     (smp),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (smp.out_valid === 1'b1)
            n_valid++;
    end

    // Hand-computed 3711*sin(9deg*k) for the lobe; -1 marks indices whose value is not checked.
    function automatic int ref_lobe(input int j);
        if (j <= 20)
            return 0;
        case (j)
            22, 38:  return 1147;
            23, 37:  return 1685;
            24, 36:  return 2181;
            25, 35:  return 2624;
            26, 34:  return 3002;
            28, 32:  return 3529;
            29, 31:  return 3665;
            30:      return 3711;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input string tag, input int j, input int g, input int pol);
        int v;
        @(negedge clk);
        check($sformatf("%s[%0d] out_valid", tag, j), int'(smp.out_valid), 1);
        check($sformatf("%s[%0d] period_start", tag, j), int'(smp.period_start), (j == 0) ? 1 : 0);
        check($sformatf("%s[%0d] polarity", tag, j), int'(smp.polarity), pol);
        v = ref_lobe(j);
        if (v >= 0)
            check($sformatf("%s[%0d] sine_out", tag, j), int'(smp.sine_out), (v * g) >> 8);
    endtask

    initial begin
        @(negedge clk);
        check("reset sine_out", int'(smp.sine_out), 0);
        check("reset out_valid", int'(smp.out_valid), 0);
        check("reset period_start", int'(smp.period_start), 0);
        check("reset polarity", int'(smp.polarity), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;

        @(negedge clk);
        en   = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        check("start busy", int'(busy), 1);
        check("start no early valid a", int'(smp.out_valid), 0);
        @(negedge clk);
        check("start no early valid b", int'(smp.out_valid), 0);

        for (int j = 0; j < 40; j++) begin
            if (j == 10) gain = 9'd128;
            sample("p1", j, 256, 0);
        end
        for (int j = 0; j < 40; j++) begin
            if (j == 5) gain = 9'd400;
            sample("p2", j, 128, 1);
        end
        for (int j = 0; j < 40; j++) begin
            if (j == 12) en = 1'b0;
            if (j == 20) en = 1'b1;
            sample("p3", j, 256, 0);
            if (j == 15) check("stopping busy", int'(busy), 1);
        end
        for (int j = 0; j < 40; j++) begin
            if (j == 12) en = 1'b0;
            sample("p4", j, 256, 1);
        end
        @(negedge clk);
        check("stop out_valid", int'(smp.out_valid), 0);
        check("stop busy", int'(busy), 0);
        base = n_valid;
        repeat (6) @(negedge clk);
        check("idle ticks ignored", n_valid - base, 0);

        oneshot = 1'b1;
        en      = 1'b1;
        base    = n_valid;
        repeat (50) @(negedge clk);
        check("oneshot pulses", n_valid - base, 40);
        check("oneshot busy", int'(busy), 0);
        repeat (8) @(negedge clk);
        check("oneshot no rerun", n_valid - base, 40);
        en      = 1'b0;
        oneshot = 1'b0;
        @(negedge clk);

        en = 1'b1;
        repeat (27) @(negedge clk);
        check("pre-reset sine_out idx24", int'(smp.sine_out), 2181);
        check("pre-reset polarity", int'(smp.polarity), 1);
        rst = 1'b1;
        #1;
        check("async reset sine_out", int'(smp.sine_out), 0);
        check("async reset out_valid", int'(smp.out_valid), 0);
        check("async reset polarity", int'(smp.polarity), 0);
        check("async reset busy", int'(busy), 0);
        base = n_valid;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("no in-flight valid", n_valid - base, 0);
        sample("rst", 0, 256, 0);
        check("post-reset busy", int'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
